// File: rtl/risc_run_ctrl.sv
// Run/step/breakpoint controller that paces a small RISC core through a registered one-clk core_en.
// The step/resume button is synchronised and debounced on-chip.
module risc_run_ctrl #(
  parameter int DIV       = 4,
  parameter int DB_CYCLES = 3,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 button,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  output logic                 core_en,
  output logic                 halted,
  output logic                 bp_hit,
  output logic [CNT_WIDTH-1:0] step_count
);

  // state  | meaning
  // HALT   | core stopped, button ignored
  // RUN    | core_en on every divider tick
  // STEP   | one core_en per debounced button press
  // RUNBP  | like RUN, stops when the tick finds pc == bp_addr
  // BREAK  | stopped at breakpoint, waiting for press or mode change
  // RESUME | one unconditional core_en to step off the breakpoint
  typedef enum logic [2:0] {S_HALT, S_RUN, S_STEP, S_RUNBP, S_BREAK, S_RESUME} state_t;

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DB_W  = $clog2(DB_CYCLES + 1);

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d;
  logic                 db_level_q, db_level_d, db_prev_q, db_prev_d;
  logic [DB_W-1:0]      db_cnt_q, db_cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 core_en_q, core_en_d;
  logic [CNT_WIDTH-1:0] step_q, step_d;
  logic                 btn_press, running, tick, bp_match;

  function automatic state_t mode_state(input logic [1:0] m);
    case (m)
      2'b01:   return S_RUN;
      2'b10:   return S_STEP;
      2'b11:   return S_RUNBP;
      default: return S_HALT;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_HALT;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
      div_q      <= '0;
      core_en_q  <= 1'b0;
      step_q     <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_level_q <= db_level_d;
      db_prev_q  <= db_prev_d;
      db_cnt_q   <= db_cnt_d;
      div_q      <= div_d;
      core_en_q  <= core_en_d;
      step_q     <= step_d;
    end
  end

  // Debounce: any cycle where the synced level agrees restarts the count.
  always_comb begin
    sync1_d    = button;
    sync2_d    = sync1_q;
    db_prev_d  = db_level_q;
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_W'(DB_CYCLES - 1)) db_level_d = sync2_q;
      else                                  db_cnt_d   = db_cnt_q + DB_W'(1);
    end
  end

  assign btn_press = db_level_q & ~db_prev_q;
  assign running   = (state_q == S_RUN) || (state_q == S_RUNBP);
  assign tick      = running && (div_q == DIV_W'(DIV - 1));
  assign bp_match  = (pc == bp_addr);

  // The divider keeps its phase across RUN <-> RUNBP since both count as running.
  always_comb begin
    div_d = '0;
    if (running && !tick) div_d = div_q + DIV_W'(1);
  end

  always_comb begin
    state_d   = mode_state(mode);
    core_en_d = 1'b0;
    halted    = 1'b0;
    bp_hit    = 1'b0;
    case (state_q)
      S_HALT: halted = 1'b1;
      S_RUN:  core_en_d = tick;
      S_STEP: begin
        core_en_d = btn_press;
        halted    = ~btn_press;
      end
      S_RUNBP: begin
        core_en_d = tick && !bp_match;
        if (mode == 2'b11 && tick && bp_match) state_d = S_BREAK;
      end
      S_BREAK: begin
        halted = 1'b1;
        bp_hit = 1'b1;
        if (mode == 2'b11) state_d = btn_press ? S_RESUME : S_BREAK;
      end
      S_RESUME: begin
        core_en_d = 1'b1;
        state_d   = S_RUNBP;
      end
      default: state_d = S_HALT;
    endcase
  end

  assign step_d     = step_q + CNT_WIDTH'(core_en_q);
  assign core_en    = core_en_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Randomised and directed bench for risc_run_ctrl against a cycle-level behavioural model.
module tb_risc_run_ctrl;

  localparam int DIV   = 4;
  localparam int DB    = 3;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  localparam int MS_HALT = 0, MS_RUN = 1, MS_STEP = 2, MS_RUNBP = 3, MS_BREAK = 4, MS_RESUME = 5;

  logic             clk, rst, button;
  logic [1:0]       mode;
  logic [PC_W-1:0]  pc, bp_addr;
  logic             core_en, halted, bp_hit;
  logic [CNT_W-1:0] step_count;

  risc_run_ctrl #(.DIV(DIV), .DB_CYCLES(DB), .PC_WIDTH(PC_W), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .button(button), .pc(pc), .bp_addr(bp_addr),
    .core_en(core_en), .halted(halted), .bp_hit(bp_hit), .step_count(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, pulses = 0;

  // reference model state
  int m_state, m_run, m_step, m_pcn;
  bit m_en, m_s1, m_s2, m_db, m_db_prev;
  bit hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int from_mode(input logic [1:0] m);
    return (m == 2'd1) ? MS_RUN : (m == 2'd2) ? MS_STEP : (m == 2'd3) ? MS_RUNBP : MS_HALT;
  endfunction

  task automatic model_reset();
    m_state = MS_HALT; m_run = 0; m_step = 0; m_pcn = 0;
    m_en = 0; m_s1 = 0; m_s2 = 0; m_db = 0; m_db_prev = 0;
    hist.delete();
  endtask

  // Applies one rising edge to the model using the inputs present just before it.
  task automatic model_edge();
    bit press, run, tk, en, flip;
    int nxt;
    press = m_db && !m_db_prev;
    run   = (m_state == MS_RUN) || (m_state == MS_RUNBP);
    tk    = run && (m_run % DIV == DIV - 1);
    nxt   = from_mode(mode);
    en    = 0;
    case (m_state)
      MS_RUN:    en = tk;
      MS_STEP:   en = press;
      MS_RUNBP: begin
        en = tk && (pc != bp_addr);
        if (mode == 2'd3 && tk && pc == bp_addr) nxt = MS_BREAK;
      end
      MS_BREAK:  if (mode == 2'd3) nxt = press ? MS_RESUME : MS_BREAK;
      MS_RESUME: begin en = 1; nxt = MS_RUNBP; end
      default: ;
    endcase
    if (m_en) m_pcn++;
    m_step = (m_step + int'(m_en)) % (1 << CNT_W);
    m_en   = en;
    m_run  = run ? (m_run + 1) % DIV : 0;
    m_state = nxt;
    hist.push_back(m_s2);
    if (hist.size() > DB) void'(hist.pop_front());
    flip = (hist.size() == DB);
    foreach (hist[k]) if (hist[k] == m_db) flip = 0;
    m_db_prev = m_db;
    if (flip) begin m_db = !m_db; hist.delete(); end
    m_s2 = m_s1;
    m_s1 = button;
  endtask

  function automatic bit exp_halted();
    return (m_state == MS_HALT) || (m_state == MS_BREAK) ||
           (m_state == MS_STEP && !(m_db && !m_db_prev));
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (core_en === 1'b1) pulses++;
    check("core_en", core_en, m_en);
    check("step_count", step_count, m_step);
    check("halted", halted, exp_halted());
    check("bp_hit", bp_hit, m_state == MS_BREAK);
    pc = PC_W'(4 * (m_pcn % 32));
  endtask

  // Asserts reset immediately (no clock edge) and releases it at the next falling edge.
  task automatic reset_now();
    rst = 1'b0;
    #1;
    check("rst_core_en", core_en, 0);
    check("rst_halted", halted, 1);
    check("rst_bp_hit", bp_hit, 0);
    check("rst_step_count", step_count, 0);
    model_reset();
    mode = 2'd0; button = 1'b0; pc = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int  mode_hold, btn_hold;
    bit  seen;
    rst = 1'b0; mode = 2'd0; button = 1'b0; pc = '0; bp_addr = 32'h10;
    model_reset();
    #1;
    reset_now();

    // free run
    pulses = 0; mode = 2'd1;
    repeat (22) cyc();
    check("free_run_pulses", pulses, 5);
    check("free_run_step", step_count, 5);
    check("free_run_halted", halted, 0);

    // debounce in single-step
    reset_now();
    mode = 2'd2;
    repeat (3) cyc();
    pulses = 0;
    button = 1'b1; repeat (2) cyc();
    button = 1'b0; repeat (10) cyc();
    check("glitch_pulses", pulses, 0);
    button = 1'b1; repeat (50) cyc();
    button = 1'b0; repeat (10) cyc();
    check("held_pulses", pulses, 1);
    check("held_step", step_count, 1);

    // run to breakpoint, then resume
    reset_now();
    bp_addr = 32'h10; mode = 2'd3; pulses = 0;
    repeat (30) cyc();
    check("bp_pulses", pulses, 4);
    check("bp_step", step_count, 4);
    check("bp_hit_set", bp_hit, 1);
    check("bp_halted", halted, 1);
    pulses = 0; button = 1'b1; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc();
      if (core_en === 1'b1) seen = 1;
    end
    check("resume_pulse_seen", seen, 1);
    check("resume_bp_hit", bp_hit, 0);
    cyc();
    check("resume_step", step_count, 5);
    button = 1'b0;
    repeat (20) cyc();
    check("resume_running", halted, 0);

    // mode change beats press in BREAK, then reset mid-pulse
    reset_now();
    bp_addr = 32'h10; mode = 2'd3;
    repeat (30) cyc();
    button = 1'b1;
    repeat (5) cyc();
    mode = 2'd1;
    cyc();
    check("prio_left_break", bp_hit, 0);
    cyc();
    check("prio_no_resume", core_en, 0);
    button = 1'b0; seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc();
      if (core_en === 1'b1) seen = 1;
    end
    check("prio_run_pulse", seen, 1);
    reset_now();

    // step counter wrap
    mode = 2'd1; pulses = 0;
    for (int i = 0; i < 120 && pulses < 17; i++) cyc();
    check("wrap_pulses", pulses, 17);
    cyc();
    check("wrap_step", step_count, 1);

    // randomised
    reset_now();
    bp_addr = 32'h40; mode_hold = 0; btn_hold = 0;
    for (int i = 0; i < 2500; i++) begin
      if (mode_hold == 0) begin
        mode = 2'($urandom_range(0, 3));
        mode_hold = $urandom_range(5, 60);
      end else mode_hold--;
      if (btn_hold == 0) begin
        button = ~button;
        btn_hold = $urandom_range(1, 9);
      end else btn_hold--;
      if ($urandom_range(0, 499) == 0) reset_now();
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
